// File: rtl/pid_multichannel_if.sv
// Handshake, sample and configuration bundle for the multichannel PID controller.
// The bench side drives through master, the controller consumes through slave.
interface pid_multichannel_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_BITS    = 2
);
    logic                         enable;
    logic                         cfg_we;
    logic [CH_BITS-1:0]           cfg_ch;
    logic [1:0]                   cfg_sel;
    logic [DATA_WIDTH-1:0]        cfg_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [CH_BITS-1:0]           in_ch;
    logic signed [DATA_WIDTH-1:0] setpoint;
    logic signed [DATA_WIDTH-1:0] process_var;
    logic                         out_valid;
    logic                         out_ready;
    logic [CH_BITS-1:0]           out_ch;
    logic signed [DATA_WIDTH-1:0] control_output;
    logic                         out_saturated;

    modport master (
        output enable, cfg_we, cfg_ch, cfg_sel, cfg_data,
        output in_valid, in_ch, setpoint, process_var, out_ready,
        input  in_ready, out_valid, out_ch, control_output, out_saturated
    );

    modport slave (
        input  enable, cfg_we, cfg_ch, cfg_sel, cfg_data,
        input  in_valid, in_ch, setpoint, process_var, out_ready,
        output in_ready, out_valid, out_ch, control_output, out_saturated
    );
endinterface

// File: rtl/pid_multichannel.sv
// Time-multiplexed PID controller: NUM_CH loops share one MAC datapath,
// with per-channel gains, clamped integrator with anti-windup and valid/ready I/O.
module pid_multichannel #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int NUM_CH      = 4,
    parameter int CH_BITS     = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int OUTPUT_MIN  = -1000,
    parameter int OUTPUT_MAX  = 1000,
    parameter int INTEG_LIMIT = 262144
) (
    input logic               clk,
    input logic               rst,
    pid_multichannel_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int SW = ACC_WIDTH + 2;

    localparam logic signed [DW:0]    ERR_MAX  = (DW+1)'((2**(DW-1)) - 1);
    localparam logic signed [DW:0]    ERR_MIN  = (DW+1)'(-(2**(DW-1)));
    localparam logic signed [AW:0]    I_MAX    = (AW+1)'(INTEG_LIMIT);
    localparam logic signed [AW:0]    I_MIN    = (AW+1)'(-INTEG_LIMIT);
    localparam logic signed [SW-1:0]  Y_MAX    = SW'(OUTPUT_MAX);
    localparam logic signed [SW-1:0]  Y_MIN    = SW'(OUTPUT_MIN);
    localparam logic signed [DW-1:0]  ERR_ZERO = '0;

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_SUM, S_OUT} state_t;

    function automatic logic signed [DW-1:0] sat_err(input logic signed [DW:0] v);
        logic signed [DW-1:0] r;
        if (v > ERR_MAX)      r = ERR_MAX[DW-1:0];
        else if (v < ERR_MIN) r = ERR_MIN[DW-1:0];
        else                  r = v[DW-1:0];
        return r;
    endfunction

    function automatic logic signed [AW-1:0] clamp_integ(input logic signed [AW:0] v);
        logic signed [AW-1:0] r;
        if (v > I_MAX)      r = I_MAX[AW-1:0];
        else if (v < I_MIN) r = I_MIN[AW-1:0];
        else                r = v[AW-1:0];
        return r;
    endfunction

    state_t state_r, state_s;

    logic [CH_BITS-1:0]   ch_r;
    logic signed [DW-1:0] sp_r, pv_r, kp_r, ki_r, kd_r;
    logic signed [DW-1:0] err_r;
    logic signed [DW:0]   derr_r;
    logic signed [AW-1:0] p_r, icand_r;
    logic signed [AW:0]   d_r;

    logic                 out_valid_r, sat_r;
    logic [CH_BITS-1:0]   out_ch_r;
    logic signed [DW-1:0] ctrl_r;

    logic signed [DW-1:0] kp_mem_r [NUM_CH];
    logic signed [DW-1:0] ki_mem_r [NUM_CH];
    logic signed [DW-1:0] kd_mem_r [NUM_CH];
    logic signed [AW-1:0] integ_r  [NUM_CH];
    logic signed [DW-1:0] prev_err_r [NUM_CH];

    logic                 in_ready_s, accept_s;
    logic                 ch_ok_s, in_ok_s, cfg_ok_s;
    logic [CH_BITS-1:0]   idx_s, in_idx_s, cfg_idx_s;
    logic signed [DW:0]   err_wide_s, derr_s;
    logic signed [DW-1:0] err_s;
    logic signed [AW-1:0] p_s, icand_s;
    logic signed [AW:0]   integ_sum_s, d_s;
    logic signed [SW-1:0] sum_s, y_s;
    logic signed [DW-1:0] ctrl_s;
    logic                 sat_s, hold_s;

    assign in_ready_s = (state_r == S_IDLE) && bus.enable && !rst;
    assign accept_s   = in_ready_s && bus.in_valid;

    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = out_valid_r;
    assign bus.out_ch         = out_ch_r;
    assign bus.control_output = ctrl_r;
    assign bus.out_saturated  = sat_r;

    // Channel-range guards; out-of-range channels map to index 0 but never write back.
    always_comb begin
        ch_ok_s   = (int'(ch_r) < NUM_CH);
        in_ok_s   = (int'(bus.in_ch) < NUM_CH);
        cfg_ok_s  = (int'(bus.cfg_ch) < NUM_CH);
        idx_s     = ch_ok_s  ? ch_r       : '0;
        in_idx_s  = in_ok_s  ? bus.in_ch  : '0;
        cfg_idx_s = cfg_ok_s ? bus.cfg_ch : '0;
    end

    // Shared arithmetic for the ERR, MUL and SUM stages.
    always_comb begin
        err_wide_s  = {sp_r[DW-1], sp_r} - {pv_r[DW-1], pv_r};
        err_s       = sat_err(err_wide_s);
        derr_s      = {err_s[DW-1], err_s} - {prev_err_r[idx_s][DW-1], prev_err_r[idx_s]};
        p_s         = AW'(kp_r) * AW'(err_r);
        integ_sum_s = (AW+1)'(integ_r[idx_s]) + (AW+1)'(ki_r) * (AW+1)'(err_r);
        icand_s     = clamp_integ(integ_sum_s);
        d_s         = (AW+1)'(kd_r) * (AW+1)'(derr_r);
        sum_s       = SW'(p_r) + SW'(icand_r) + SW'(d_r);
        y_s         = sum_s >>> FRAC_BITS;
        if (y_s > Y_MAX) begin
            ctrl_s = Y_MAX[DW-1:0];
            sat_s  = 1'b1;
        end else if (y_s < Y_MIN) begin
            ctrl_s = Y_MIN[DW-1:0];
            sat_s  = 1'b1;
        end else begin
            ctrl_s = y_s[DW-1:0];
            sat_s  = 1'b0;
        end
        // Freeze the integrator only when it would push further into saturation.
        hold_s = ((y_s > Y_MAX) && (err_r > ERR_ZERO)) ||
                 ((y_s < Y_MIN) && (err_r < ERR_ZERO));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: if (accept_s) state_s = S_ERR; else state_s = S_IDLE;
            S_ERR:  state_s = S_MUL;
            S_MUL:  state_s = S_SUM;
            S_SUM:  state_s = S_OUT;
            S_OUT:  if (bus.out_ready) state_s = S_IDLE; else state_s = S_OUT;
            default: state_s = S_IDLE;
        endcase
    end

    // Pipeline registers and the held output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_r <= '0; sp_r <= '0; pv_r <= '0;
            kp_r <= '0; ki_r <= '0; kd_r <= '0;
            err_r <= '0; derr_r <= '0;
            p_r <= '0; icand_r <= '0; d_r <= '0;
            out_valid_r <= 1'b0; out_ch_r <= '0; ctrl_r <= '0; sat_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        ch_r <= bus.in_ch;
                        sp_r <= bus.setpoint;
                        pv_r <= bus.process_var;
                        kp_r <= in_ok_s ? kp_mem_r[in_idx_s] : '0;
                        ki_r <= in_ok_s ? ki_mem_r[in_idx_s] : '0;
                        kd_r <= in_ok_s ? kd_mem_r[in_idx_s] : '0;
                    end
                end
                S_ERR: begin
                    err_r  <= err_s;
                    derr_r <= derr_s;
                end
                S_MUL: begin
                    p_r     <= p_s;
                    icand_r <= icand_s;
                    d_r     <= d_s;
                end
                S_SUM: begin
                    out_valid_r <= 1'b1;
                    out_ch_r    <= ch_r;
                    ctrl_r      <= ch_ok_s ? ctrl_s : '0;
                    sat_r       <= ch_ok_s && sat_s;
                end
                S_OUT: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Per-channel gains and loop state; a clear issued alongside write-back wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                kp_mem_r[i]   <= '0;
                ki_mem_r[i]   <= '0;
                kd_mem_r[i]   <= '0;
                integ_r[i]    <= '0;
                prev_err_r[i] <= '0;
            end
        end else begin
            if ((state_r == S_SUM) && ch_ok_s) begin
                prev_err_r[idx_s] <= err_r;
                if (!hold_s) integ_r[idx_s] <= icand_r;
            end
            if (bus.cfg_we && cfg_ok_s) begin
                case (bus.cfg_sel)
                    2'd0: kp_mem_r[cfg_idx_s] <= bus.cfg_data;
                    2'd1: ki_mem_r[cfg_idx_s] <= bus.cfg_data;
                    2'd2: kd_mem_r[cfg_idx_s] <= bus.cfg_data;
                    2'd3: begin
                        integ_r[cfg_idx_s]    <= '0;
                        prev_err_r[cfg_idx_s] <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pid_multichannel.sv
// Scoreboard bench for pid_multichannel: a behavioural PID model predicts each
// result at accept time, a monitor compares whenever out_valid is presented.
module tb_pid_multichannel;
    localparam int DW  = 16;
    localparam int CHB = 2;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pid_multichannel_if #(.DATA_WIDTH(DW), .CH_BITS(CHB)) bus();

    pid_multichannel #(.DATA_WIDTH(DW), .FRAC_BITS(8), .NUM_CH(NCH), .CH_BITS(CHB),
                       .ACC_WIDTH(32), .OUTPUT_MIN(-1000), .OUTPUT_MAX(1000),
                       .INTEG_LIMIT(262144))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int ch;
        int val;
        bit sat;
        int acc;
    } exp_t;

    exp_t   q[$];
    longint kp_m[NCH], ki_m[NCH], kd_m[NCH], integ_m[NCH], prev_m[NCH];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    bit     bp_hold = 1'b0;
    bit     rand_ready = 1'b0;
    bit     fresh = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint s16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return longint'(t);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            kp_m[i] = 0; ki_m[i] = 0; kd_m[i] = 0; integ_m[i] = 0; prev_m[i] = 0;
        end
    endfunction

    function automatic void model_cfg(input int ch, input int sel, input int data);
        case (sel)
            0: kp_m[ch] = s16(data);
            1: ki_m[ch] = s16(data);
            2: kd_m[ch] = s16(data);
            default: begin integ_m[ch] = 0; prev_m[ch] = 0; end
        endcase
    endfunction

    // PID law in plain integer arithmetic, including the channel state update.
    function automatic exp_t model(input int ch, input int sp, input int pv);
        longint err, derr, p, ic, d, sum, y;
        exp_t e;
        err = longint'(sp) - longint'(pv);
        if (err > 32767)  err = 32767;
        if (err < -32768) err = -32768;
        derr = err - prev_m[ch];
        p  = kp_m[ch] * err;
        ic = integ_m[ch] + ki_m[ch] * err;
        if (ic > 262144)  ic = 262144;
        if (ic < -262144) ic = -262144;
        d   = kd_m[ch] * derr;
        sum = p + ic + d;
        y   = sum >>> 8;
        e.ch  = ch;
        e.sat = (y > 1000) || (y < -1000);
        e.val = (y > 1000) ? 1000 : ((y < -1000) ? -1000 : int'(y));
        e.acc = 0;
        prev_m[ch] = err;
        if (!((y > 1000 && err > 0) || (y < -1000 && err < 0))) integ_m[ch] = ic;
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic cfg(input int ch, input int sel, input int data);
        if (sel == 3) wait_idle();
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_ch = ch[CHB-1:0]; bus.cfg_sel = sel[1:0]; bus.cfg_data = data[DW-1:0];
        model_cfg(ch, sel, data);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    // Offer one sample; an optional gain write is issued on the accepting edge itself.
    task automatic send(input int ch, input int sp, input int pv,
                        input bit cw = 1'b0, input int csel = 0, input int cch = 0, input int cdata = 0);
        int n = 0;
        exp_t e;
        @(negedge clk);
        bus.in_ch = ch[CHB-1:0]; bus.setpoint = sp[DW-1:0]; bus.process_var = pv[DW-1:0];
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready) begin
            n++;
            if (n > 200) begin
                vectors++; miscompares++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1");
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
        end
        if (cw) begin
            bus.cfg_we = 1'b1; bus.cfg_ch = cch[CHB-1:0]; bus.cfg_sel = csel[1:0]; bus.cfg_data = cdata[DW-1:0];
        end
        e = model(ch, sp, pv);
        e.acc = cyc + 1;
        q.push_back(e);
        if (cw) model_cfg(cch, csel, cdata);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
    endtask

    // Downstream ready, changed away from the sampling edge.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            bus.out_ready = bp_hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: compare every presented result against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_output: got out_valid=1 expected 0");
                end else begin
                    chk("out_ch", longint'(bus.out_ch), q[0].ch);
                    chk("control_output", longint'(bus.control_output), q[0].val);
                    chk("out_saturated", longint'(bus.out_saturated), q[0].sat);
                    chk("in_ready_while_busy", longint'(bus.in_ready), 0);
                    if (fresh) begin
                        chk("latency", cyc - q[0].acc, 3);
                        fresh = 1'b0;
                    end
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        fresh = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int ch, sp, pv;
        rst = 1'b1;
        bus.enable = 1'b1; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_sel = '0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.setpoint = '0; bus.process_var = '0;
        model_reset();
        #22;
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_ch", longint'(bus.out_ch), 0);
        chk("rst_control_output", longint'(bus.control_output), 0);
        chk("rst_out_saturated", longint'(bus.out_saturated), 0);
        @(negedge clk); rst = 1'b0;

        // Step response on ch0, repeated.
        cfg(0, 0, 'h100); cfg(0, 1, 'h40); cfg(0, 2, 'h80);
        send(0, 100, 0);
        send(0, 100, 0);

        // Output clamp both ways, then error saturation on ch1.
        cfg(1, 0, 'h100);
        send(1, 2000, 0);
        send(1, -2000, 0);
        send(1, 32767, -32768);

        // Anti-windup on ch3.
        cfg(3, 0, 'h100); cfg(3, 1, 'h40);
        repeat (3) send(3, 2000, 0);
        send(3, 0, 0);

        // Channel isolation and clear.
        cfg(2, 0, 'h100); cfg(2, 1, 'h40); cfg(2, 2, 'h80);
        send(0, 100, 0); send(2, 100, 0); send(0, 100, 0); send(2, 100, 0);
        cfg(0, 3, 0);
        send(0, 100, 0);

        // Gain write on the accepting edge must not affect that sample.
        send(2, 40, 10, 1'b1, 0, 2, 'h300);
        send(2, 40, 10);

        // Backpressure: result held for a dozen cycles.
        wait_idle();
        bp_hold = 1'b1;
        send(0, 50, 10);
        repeat (12) @(negedge clk);
        bp_hold = 1'b0;

        // Enable dropped while the sample is in MUL.
        send(1, 300, 0);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_ch = 2'd2;
        repeat (10) begin
            @(negedge clk); #1;
            chk("no_accept_disabled", longint'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        wait_idle();
        bus.enable = 1'b1;

        // Randomised traffic with random downstream stalls.
        rand_ready = 1'b1;
        for (int n = 0; n < 150; n++) begin
            ch = int'($urandom_range(0, NCH - 1));
            if ($urandom_range(0, 1) == 0) begin
                sp = int'($urandom_range(0, 600)) - 300;
                pv = int'($urandom_range(0, 600)) - 300;
            end else begin
                sp = int'($urandom_range(0, 65535)) - 32768;
                pv = int'($urandom_range(0, 65535)) - 32768;
            end
            if ($urandom_range(0, 19) == 0) cfg(ch, 3, 0);
            if ($urandom_range(0, 3) == 0)
                send(ch, sp, pv, 1'b1, int'($urandom_range(0, 2)), int'($urandom_range(0, NCH - 1)),
                     int'($urandom_range(0, 1023)) - 512);
            else
                send(ch, sp, pv);
        end
        rand_ready = 1'b0;
        wait_idle();

        // Reset while a sample is in MUL: output drops at once, gains are gone.
        cfg(1, 0, 'h100);
        send(1, 32767, -32768);
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        fresh = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_out_valid", longint'(bus.out_valid), 0);
        chk("rst_mid_in_ready", longint'(bus.in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(1, 32767, -32768);
        send(0, 100, 0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
